// File: rtl/io_bus_pkg.sv
// Shared encodings and defaults for the active-low I/O bus initiator.
// Contains the bus and interrupt state types, the interrupt vectors and the idle strobe value.
package io_bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD      = 2'd1,
      WR      = 2'd2,
      WR_HOLD = 2'd3
   } bus_state_t;

   typedef enum logic [1:0] {
      I_IDLE = 2'd0,
      I_PEND = 2'd1,
      I_WAIT = 2'd2
   } intr_state_t;

   localparam logic [1:0] VEC_FINTR_DEF = 2'b10;
   localparam logic [1:0] VEC_INTR_DEF  = 2'b01;

   // Ordered as {CS_, RD_, WR_}
   localparam logic [2:0] STROBE_IDLE = 3'b111;
   localparam logic [2:0] STROBE_RD   = 3'b001;
   localparam logic [2:0] STROBE_WR   = 3'b010;

endpackage

// File: rtl/io_intr_arb.sv
// Interrupt arbiter: latches the highest-priority request, holds it for the CPU,
// and issues a one-cycle acknowledge to the device once the CPU accepts it.
module io_intr_arb
   import io_bus_pkg::*;
#(
   parameter logic [1:0] VEC_FINTR = VEC_FINTR_DEF,
   parameter logic [1:0] VEC_INTR  = VEC_INTR_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fintr,
   input  logic       intr,
   input  logic       irq_ack,
   output logic       irq,
   output logic [1:0] irq_vec,
   output logic       int_ack
);

   intr_state_t state, state_nxt;
   logic        src_fast, src_fast_nxt;
   logic        irq_nxt, int_ack_nxt;
   logic [1:0]  vec_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= I_IDLE;
         src_fast <= 1'b0;
         irq      <= 1'b0;
         irq_vec  <= 2'b00;
         int_ack  <= 1'b0;
      end else begin
         state    <= state_nxt;
         src_fast <= src_fast_nxt;
         irq      <= irq_nxt;
         irq_vec  <= vec_nxt;
         int_ack  <= int_ack_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      src_fast_nxt = src_fast;
      irq_nxt      = irq;
      vec_nxt      = irq_vec;
      int_ack_nxt  = 1'b0;
      case (state)
         I_IDLE: begin
            if (fintr) begin
               src_fast_nxt = 1'b1;
               vec_nxt      = VEC_FINTR;
               irq_nxt      = 1'b1;
               state_nxt    = I_PEND;
            end else if (intr) begin
               src_fast_nxt = 1'b0;
               vec_nxt      = VEC_INTR;
               irq_nxt      = 1'b1;
               state_nxt    = I_PEND;
            end
         end
         I_PEND: begin
            if (irq_ack) begin
               irq_nxt     = 1'b0;
               int_ack_nxt = 1'b1;
               state_nxt   = I_WAIT;
            end
         end
         I_WAIT: begin
            // Only the line that was served must drop; the other may already be pending
            if (src_fast ? !fintr : !intr) state_nxt = I_IDLE;
         end
         default: state_nxt = I_IDLE;
      endcase
   end

endmodule

// File: rtl/io_bus_master.sv
// CPU-side initiator for the active-low memory-mapped I/O bus with
// registered strobes, a tri-state data driver and an interrupt arbiter.
module io_bus_master
   import io_bus_pkg::*;
#(
   parameter int         ADDR_W    = 10,
   parameter int         DATA_W    = 32,
   parameter int         RD_WAIT   = 1,
   parameter logic [1:0] VEC_FINTR = VEC_FINTR_DEF,
   parameter logic [1:0] VEC_INTR  = VEC_INTR_DEF
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic              busy,
   output logic [ADDR_W-1:0] Addr,
   inout  wire  [DATA_W-1:0] Data,
   output logic              CS_,
   output logic              RD_,
   output logic              WR_,
   output logic              Enable,
   input  logic              fintr,
   input  logic              intr,
   output logic              irq,
   output logic [1:0]        irq_vec,
   input  logic              irq_ack,
   output logic              int_ack
);

   localparam logic [2:0] RD_LAST = 3'(RD_WAIT);

   bus_state_t        state, state_nxt;
   logic [2:0]        cnt, cnt_nxt;
   logic [2:0]        strobe_nxt;
   logic              data_oe, oe_nxt;
   logic [DATA_W-1:0] data_q, wdata_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic              done_nxt, capture;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state          <= IDLE;
         cnt            <= '0;
         {CS_, RD_, WR_} <= STROBE_IDLE;
         data_oe        <= 1'b0;
         data_q         <= '0;
         Addr           <= '0;
         done           <= 1'b0;
         rdata          <= '0;
         Enable         <= 1'b0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         {CS_, RD_, WR_} <= strobe_nxt;
         data_oe        <= oe_nxt;
         data_q         <= wdata_nxt;
         Addr           <= addr_nxt;
         done           <= done_nxt;
         Enable         <= 1'b1;
         if (capture) rdata <= Data;
      end
   end

   // Outputs are computed for the state being entered so every bus pin comes straight from a flop
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      strobe_nxt = STROBE_IDLE;
      oe_nxt     = 1'b0;
      wdata_nxt  = data_q;
      addr_nxt   = Addr;
      done_nxt   = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               addr_nxt  = addr;
               wdata_nxt = wdata;
               cnt_nxt   = '0;
               if (we) begin
                  state_nxt  = WR;
                  strobe_nxt = STROBE_WR;
                  oe_nxt     = 1'b1;
               end else begin
                  state_nxt  = RD;
                  strobe_nxt = STROBE_RD;
               end
            end
         end
         RD: begin
            if (cnt == RD_LAST) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
               capture   = 1'b1;
            end else begin
               cnt_nxt    = cnt + 3'd1;
               strobe_nxt = STROBE_RD;
            end
         end
         WR: begin
            state_nxt = WR_HOLD;
            oe_nxt    = 1'b1;
         end
         WR_HOLD: begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign Data = data_oe ? data_q : {DATA_W{1'bz}};

   io_intr_arb #(
      .VEC_FINTR (VEC_FINTR),
      .VEC_INTR  (VEC_INTR)
   ) u_intr (
      .clk     (Clk),
      .rst     (Rst),
      .fintr   (fintr),
      .intr    (intr),
      .irq_ack (irq_ack),
      .irq     (irq),
      .irq_vec (irq_vec),
      .int_ack (int_ack)
   );

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: two instances (RD_WAIT=1 and RD_WAIT=3), a device memory
// model on each bus, and a reference memory for expected read data.
module tb_io_bus_master;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [9:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic        sel = 1'b0;
   logic        fintr = 1'b0;
   logic        intr = 1'b0;
   logic        irq_ack = 1'b0;

   int total = 0;
   int bad = 0;

   always #5 Clk = ~Clk;

   // instance A: RD_WAIT = 1
   logic [31:0] a_rdata;
   logic        a_done, a_busy, a_cs, a_rd, a_wr, a_en, a_irq, a_int_ack;
   logic [9:0]  a_addr;
   logic [1:0]  a_vec;
   wire  [31:0] a_data;
   logic [31:0] a_mem [0:1023] = '{default: '0};

   // instance B: RD_WAIT = 3
   logic [31:0] b_rdata;
   logic        b_done, b_busy, b_cs, b_rd, b_wr, b_en, b_irq, b_int_ack;
   logic [9:0]  b_addr;
   logic [1:0]  b_vec;
   wire  [31:0] b_data;
   logic [31:0] b_mem [0:1023] = '{default: '0};

   wire a_req = req & ~sel;
   wire b_req = req & sel;

   io_bus_master #(.ADDR_W(10), .DATA_W(32), .RD_WAIT(1)) u_dut_a (
      .Clk(Clk), .Rst(Rst), .req(a_req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(a_rdata), .done(a_done), .busy(a_busy), .Addr(a_addr), .Data(a_data),
      .CS_(a_cs), .RD_(a_rd), .WR_(a_wr), .Enable(a_en),
      .fintr(fintr), .intr(intr), .irq(a_irq), .irq_vec(a_vec),
      .irq_ack(irq_ack), .int_ack(a_int_ack)
   );

   io_bus_master #(.ADDR_W(10), .DATA_W(32), .RD_WAIT(3)) u_dut_b (
      .Clk(Clk), .Rst(Rst), .req(b_req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(b_rdata), .done(b_done), .busy(b_busy), .Addr(b_addr), .Data(b_data),
      .CS_(b_cs), .RD_(b_rd), .WR_(b_wr), .Enable(b_en),
      .fintr(1'b0), .intr(1'b0), .irq(b_irq), .irq_vec(b_vec),
      .irq_ack(1'b0), .int_ack(b_int_ack)
   );

   // Device models: drive data while read-selected, store on an edge with write strobe low
   assign a_data = (!a_cs && !a_rd) ? a_mem[a_addr] : 32'bz;
   assign b_data = (!b_cs && !b_rd) ? b_mem[b_addr] : 32'bz;
   always @(posedge Clk) if (!a_cs && !a_wr) a_mem[a_addr] <= a_data;
   always @(posedge Clk) if (!b_cs && !b_wr) b_mem[b_addr] <= b_data;

   wire        cs_m    = sel ? b_cs : a_cs;
   wire        rd_m    = sel ? b_rd : a_rd;
   wire        wr_m    = sel ? b_wr : a_wr;
   wire        done_m  = sel ? b_done : a_done;
   wire [9:0]  addr_m  = sel ? b_addr : a_addr;
   wire [31:0] data_m  = sel ? b_data : a_data;
   wire [31:0] rdata_m = sel ? b_rdata : a_rdata;

   // Reference memory keyed by {instance, address}
   logic [31:0] ref_mem [int];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issues one request at the current negedge and watches ncyc cycles after acceptance.
   // hold>0 keeps req high for that many busy cycles with a different command.
   task automatic run_xfer(input bit s, input bit w, input logic [9:0] a, input logic [31:0] d,
                           input int hold, input int ncyc,
                           output int n_cs, output int n_rd, output int n_wr,
                           output int first_done, output int n_done,
                           output logic [9:0] a0, output logic [31:0] d0, output logic [31:0] d1);
      sel = s; req = 1'b1; we = w; addr = a; wdata = d;
      n_cs = 0; n_rd = 0; n_wr = 0; first_done = -1; n_done = 0;
      a0 = '0; d0 = '0; d1 = '0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge Clk);
         if (c == 0) begin a0 = addr_m; d0 = data_m; end
         if (c == 1) d1 = data_m;
         if (!cs_m) n_cs++;
         if (!rd_m) n_rd++;
         if (!wr_m) n_wr++;
         if (done_m) begin
            n_done++;
            if (first_done < 0) first_done = c;
         end
         if (c == 0 && hold > 0) begin addr = a ^ 10'h3ff; wdata = ~d; we = ~w; end
         if (c >= hold) req = 1'b0;
      end
      req = 1'b0;
   endtask

   task automatic do_write(input bit s, input logic [9:0] a, input logic [31:0] d);
      int n_cs, n_rd, n_wr, fd, nd;
      logic [9:0] a0;
      logic [31:0] d0, d1;
      run_xfer(s, 1'b1, a, d, 0, 4, n_cs, n_rd, n_wr, fd, nd, a0, d0, d1);
      ref_mem[int'(s) * 1024 + int'(a)] = d;
      check("wr_addr", 64'(a0), 64'(a));
      check("wr_data", 64'(d0), 64'(d));
      check("wr_hold_data", 64'(d1), 64'(d));
      check("wr_cs_cycles", 64'(n_cs), 64'(1));
      check("wr_strobe_cycles", 64'(n_wr), 64'(1));
      check("wr_rd_quiet", 64'(n_rd), 64'(0));
      check("wr_done_at", 64'(fd), 64'(2));
      check("wr_done_count", 64'(nd), 64'(1));
   endtask

   task automatic do_read(input bit s, input logic [9:0] a, input int hold);
      int n_cs, n_rd, n_wr, fd, nd, rw;
      logic [9:0] a0;
      logic [31:0] d0, d1, exp;
      rw = s ? 3 : 1;
      exp = ref_mem.exists(int'(s) * 1024 + int'(a)) ? ref_mem[int'(s) * 1024 + int'(a)] : 32'h0;
      run_xfer(s, 1'b0, a, 32'h0, hold, rw + 5, n_cs, n_rd, n_wr, fd, nd, a0, d0, d1);
      check("rd_addr", 64'(a0), 64'(a));
      check("rd_cs_cycles", 64'(n_cs), 64'(rw + 1));
      check("rd_strobe_cycles", 64'(n_rd), 64'(rw + 1));
      check("rd_wr_quiet", 64'(n_wr), 64'(0));
      check("rd_done_at", 64'(fd), 64'(rw + 1));
      check("rd_done_count", 64'(nd), 64'(1));
      check("rd_data", 64'(rdata_m), 64'(exp));
   endtask

   initial begin
      int hold_cycles;
      logic [9:0]  ra;
      logic [31:0] rd_val;

      // Reset state
      @(negedge Clk);
      check("rst_strobes_a", 64'({a_cs, a_rd, a_wr}), 64'(3'b111));
      check("rst_strobes_b", 64'({b_cs, b_rd, b_wr}), 64'(3'b111));
      check("rst_addr", 64'(a_addr), 64'(0));
      check("rst_enable", 64'({a_en, b_en}), 64'(0));
      check("rst_rdata", 64'(a_rdata), 64'(0));
      check("rst_done_busy", 64'({a_done, a_busy, b_done, b_busy}), 64'(0));
      check("rst_irq", 64'({a_irq, a_vec, a_int_ack, b_irq, b_vec, b_int_ack}), 64'(0));
      @(negedge Clk);
      Rst = 1'b0;
      @(negedge Clk);
      check("enable_after_rst", 64'({a_en, b_en}), 64'(2'b11));

      // Directed write/read on both read-wait settings
      do_write(1'b0, 10'h005, 32'hDEADBEEF);
      do_read(1'b0, 10'h005, 0);
      do_write(1'b1, 10'h005, 32'hDEADBEEF);
      do_read(1'b1, 10'h005, 0);

      // Request held while busy must be ignored
      do_read(1'b0, 10'h005, 2);

      // Randomised traffic on both instances
      for (int i = 0; i < 8; i++) begin
         do_write(1'b0, 10'(i), $urandom);
         do_write(1'b1, 10'(i), $urandom);
      end
      for (int i = 0; i < 16; i++) begin
         ra = 10'($urandom_range(0, 7));
         rd_val = $urandom;
         if ($urandom_range(0, 1) == 1) do_write(1'($urandom_range(0, 1)), ra, rd_val);
         else do_read(1'($urandom_range(0, 1)), ra, 0);
      end

      // irq_ack with nothing pending is ignored
      irq_ack = 1'b1;
      @(negedge Clk);
      irq_ack = 1'b0;
      check("idle_ack_ignored", 64'({a_irq, a_int_ack}), 64'(0));

      // Both sources on the same edge: fast wins
      fintr = 1'b1; intr = 1'b1;
      @(negedge Clk);
      check("both_irq", 64'(a_irq), 64'(1));
      check("both_vec", 64'(a_vec), 64'(2'b10));
      @(negedge Clk);
      check("pend_stable", 64'({a_irq, a_vec, a_int_ack}), 64'({1'b1, 2'b10, 1'b0}));
      irq_ack = 1'b1;
      @(negedge Clk);
      irq_ack = 1'b0;
      check("fast_ack", 64'({a_irq, a_int_ack}), 64'(2'b01));
      @(negedge Clk);
      check("fast_ack_pulse", 64'(a_int_ack), 64'(0));

      // Fast line still high: nothing new may be raised
      hold_cycles = $urandom_range(2, 5);
      for (int i = 0; i < hold_cycles; i++) begin
         @(negedge Clk);
         check("held_no_irq", 64'({a_irq, a_int_ack}), 64'(0));
      end

      // Device clears fintr; normal request is served next
      fintr = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      check("intr_irq", 64'(a_irq), 64'(1));
      check("intr_vec", 64'(a_vec), 64'(2'b01));
      irq_ack = 1'b1;
      @(negedge Clk);
      irq_ack = 1'b0;
      intr = 1'b0;
      check("intr_ack", 64'({a_irq, a_int_ack}), 64'(2'b01));
      @(negedge Clk);
      @(negedge Clk);
      check("intr_quiet", 64'({a_irq, a_int_ack}), 64'(0));

      // Reset in the middle of a read with an interrupt pending
      intr = 1'b1;
      @(negedge Clk);
      check("pre_rst_irq", 64'(a_irq), 64'(1));
      sel = 1'b0; req = 1'b1; we = 1'b0; addr = 10'h005;
      @(negedge Clk);
      req = 1'b0;
      check("pre_rst_rd_active", 64'({a_cs, a_rd}), 64'(0));
      #2 Rst = 1'b1;
      #1;
      check("async_rst_strobes", 64'({a_cs, a_rd, a_wr}), 64'(3'b111));
      check("async_rst_busy_irq", 64'({a_busy, a_irq, a_int_ack}), 64'(0));
      intr = 1'b0;
      @(negedge Clk);
      check("rst_no_done", 64'({a_done, a_en}), 64'(0));
      Rst = 1'b0;
      @(negedge Clk);
      check("post_rst", 64'({a_en, a_done, a_irq}), 64'(3'b100));
      do_read(1'b0, 10'h005, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/io_bus_master.md
# io_bus_master

CPU-side initiator for the active-low memory-mapped I/O bus. It turns single-word CPU read/write requests into CS_/RD_/WR_ bus cycles with a bidirectional 32-bit data bus and returns read data with a one-cycle done pulse. It also arbitrates the device's two interrupt request lines (fast and normal), presents a vectored request to the CPU, and returns the int_ack pulse that the device uses to clear its request.

## Interface
Parameters:
- ADDR_W, 10, bus address width
- DATA_W, 32, data width
- RD_WAIT, 1, extra read wait cycles (0..7) before data capture
- VEC_FINTR, 2'b10, vector reported for the fast interrupt
- VEC_INTR, 2'b01, vector reported for the normal interrupt

Ports:
- Clk  in  1  clock; all state changes on posedge
- Rst  in  1  asynchronous, active-high reset
- req  in  1  CPU request strobe; sampled only while busy=0
- we  in  1  1=write, 0=read; sampled with req
- addr  in  ADDR_W  request address; sampled with req
- wdata  in  DATA_W  write data; sampled with req
- rdata  out  DATA_W  captured read data; holds until the next read completes
- done  out  1  one-cycle completion pulse
- busy  out  1  bus FSM not in IDLE
- Addr  out  ADDR_W  bus address
- Data  inout  DATA_W  bus data; driven only during write cycles, otherwise Z
- CS_, RD_, WR_  out  1 each  active-low chip select, read strobe, write strobe
- Enable  out  1  device enable
- fintr, intr  in  1 each  level interrupt requests from the device
- irq  out  1  interrupt request to the CPU
- irq_vec  out  2  vector of the pending interrupt
- irq_ack  in  1  CPU acceptance pulse
- int_ack  out  1  one-cycle acknowledge pulse to the device

## Operation
- Bus FSM states: IDLE, RD, WR, WR_HOLD.
- IDLE with req=1: latch addr, we, wdata. Go to RD if we=0, else WR.
- req while busy=1: ignored and not queued.
- RD: CS_=0, RD_=0, Addr driven, Data=Z. Stay for 1+RD_WAIT cycles (3-bit counter). On the last edge: rdata<=Data, done=1, return to IDLE.
- WR: CS_=0, WR_=0, Data=wdata, for exactly one cycle. Then go to WR_HOLD.
- WR_HOLD: CS_=WR_=1, Data still driven as hold time. Next edge: done=1, return to IDLE.
- All bus outputs are registered. Addr holds its last value in IDLE.
- Enable: 0 in reset, 1 from the first edge after Rst falls.
- Interrupt FSM states: I_IDLE, I_PEND, I_WAIT. It runs independently of the bus FSM.
- I_IDLE: if fintr, latch VEC_FINTR; else if intr, latch VEC_INTR. Set irq=1 and go to I_PEND. Fast interrupt wins when both are high on the same edge.
- I_PEND: irq=1 and irq_vec stable. On irq_ack: irq=0, int_ack=1 for one cycle, go to I_WAIT.
- I_WAIT: wait until the latched source line is low, then go to I_IDLE. This prevents re-raising a request the device has not yet cleared.

## Timing
- Reset values: CS_=RD_=WR_=1, Data=Z, Addr=0, Enable=0, rdata=0, done=0, busy=0, irq=0, irq_vec=0, int_ack=0. Both FSMs go to IDLE.
- Edge numbering: req is accepted at edge k.
- Write: strobes are low during cycle k..k+1. The device writes at edge k+1. done is high for the cycle after edge k+2.
- Read: strobes are low from k to k+1+RD_WAIT. rdata and done update at edge k+1+RD_WAIT.
- Back-to-back transfers: a new req can be accepted on the edge where done is asserted. CS_ is then low again in the next cycle.
- Interrupt latency: a source seen at edge j gives irq=1 after edge j. int_ack is high in the cycle after the irq_ack edge.
- Reset mid-operation: the bus is released asynchronously, done is not produced, the pending irq is dropped, and int_ack goes to 0.
- irq_ack outside I_PEND is ignored.

## Structure
- Package io_bus_pkg holds:
  - bus and interrupt state encodings
  - VEC_FINTR / VEC_INTR defaults
  - the idle strobe constant 3'b111 for {CS_,RD_,WR_}
- Sub-module io_intr_arb holds the interrupt FSM (fintr, intr, irq_ack -> irq, irq_vec, int_ack). The top level keeps the bus FSM and the tri-state Data driver.

## Test plan
- Write 0xDEADBEEF to 0x005: CS_/WR_ low for exactly one cycle with Data=0xDEADBEEF, done at k+2, Data=Z afterwards.
- Read 0x005 back with RD_WAIT=1: CS_/RD_ low for 2 cycles, rdata=0xDEADBEEF and done at k+2. Repeat with RD_WAIT=3: done at k+4.
- req pulsed while busy: no extra bus cycle, exactly one done.
- fintr and intr rise on the same edge: irq_vec=2'b10. After irq_ack: one int_ack pulse. Device clears fintr, then intr is served with irq_vec=2'b01.
- Source held high after int_ack: irq stays 0 until the line drops.
- Rst asserted during RD: strobes go to 1 immediately, no done. After release, a read completes normally.
